ahb_sram_slave_core: RTL and testbench

// - Word-addressed SRAM slave core behind ahb_slave_wrapper (drives its addr/write_data/write_en/read_en).
// - Returns read_data/ready/resp, which the wrapper maps straight to HRdata/Hreadyout/Hresp.
// - Adds programmable wait states, decode/alignment error responses and optional write protection.

---
 rtl/ahb_sram_slave_core.sv | 135 +++++++++++++
 tb/tb_ahb_sram_slave_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_core.sv
// Word-addressed SRAM slave core with programmable wait states and two-cycle AHB error responses.
// Optional write protection of words at or above WPROT_START is enabled by defining AHB_SLV_WPROT_EN.
module ahb_sram_slave_core #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned WPROT_START = 768
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic [1:0]            resp
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_W  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  if ((WAIT_STATES < 1) || (WAIT_STATES > 15)) begin : g_ws_chk
    $error("ahb_sram_slave_core: WAIT_STATES must be in 1..15");
  end
  if (WPROT_START > MEM_DEPTH) begin : g_wprot_chk
    $error("ahb_sram_slave_core: WPROT_START must not exceed MEM_DEPTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [3:0]             cnt_r, cnt_nxt_s;
  logic [DATA_WIDTH-1:0]  mem_r [MEM_DEPTH];

  logic [ADDR_WIDTH:0]    diff_s;
  logic [ADDR_WIDTH-1:0]  idx_s;
  logic [IDX_W-1:0]       mem_idx_s;
  logic                   req_s, err_s, wprot_err_s;
  logic                   mem_we_s, rd_ld_s, ready_s;
  logic [1:0]             resp_s;

  // Borrow out of the subtraction flags an address below the window.
  assign diff_s    = {1'b0, addr} - {1'b0, BASE_W};
  assign idx_s     = diff_s[ADDR_WIDTH-1:0] >> 2;
  assign mem_idx_s = idx_s[IDX_W-1:0];
  assign req_s     = write_en | read_en;

`ifdef AHB_SLV_WPROT_EN
  assign wprot_err_s = write_en && (idx_s >= ADDR_WIDTH'(WPROT_START));
`else
  assign wprot_err_s = 1'b0;
`endif

  assign err_s = (addr[1:0] != 2'b00) || diff_s[ADDR_WIDTH] || (idx_s >= DEPTH_W) ||
                 (write_en && read_en) || wprot_err_s;

  // Next-state, wait counter and response decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ready_s     = 1'b1;
    resp_s      = RESP_OKAY;
    mem_we_s    = 1'b0;
    rd_ld_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = ~req_s;
        if (req_s && err_s) begin
          resp_s      = RESP_ERR;
          state_nxt_s = ST_ERR2;
        end else if (req_s) begin
          mem_we_s    = write_en;
          rd_ld_s     = read_en;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        ready_s = (cnt_r == 4'd0);
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERR2: begin
        resp_s      = RESP_ERR;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        cnt_nxt_s   = 4'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign ready = ready_s;
  assign resp  = resp_s;

  // State, counter and read-data registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      read_data <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (rd_ld_s) begin
        read_data <= mem_r[mem_idx_s];
      end
    end
  end

  // Storage array; contents survive reset, but no write lands while reset is held.
  always_ff @(posedge Hclk) begin
    if (mem_we_s && Hresetn) begin
      mem_r[mem_idx_s] <= write_data;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave_core.sv
// Directed bench: table of single transfers on a WAIT_STATES=1 core, hand sequences on a WAIT_STATES=3 core.
module tb_ahb_sram_slave_core;

  logic        Hclk;
  logic        Hresetn;
  logic [31:0] addr1, wdata1, rdata1;
  logic        we1, re1, ready1;
  logic [1:0]  resp1;
  logic [31:0] addr3, wdata3, rdata3;
  logic        we3, re3, ready3;
  logic [1:0]  resp3;

  int checks;
  int errors;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  ahb_sram_slave_core #(.WAIT_STATES(1)) dut1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .addr(addr1), .write_data(wdata1),
    .write_en(we1), .read_en(re1), .read_data(rdata1), .ready(ready1), .resp(resp1)
  );

  ahb_sram_slave_core #(.WAIT_STATES(3)) dut3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .addr(addr3), .write_data(wdata3),
    .write_en(we3), .read_en(re3), .read_data(rdata3), .ready(ready3), .resp(resp3)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One transfer on the single-wait-state core: request in N, completion/second error cycle in N+1.
  task automatic run1(input vec_t v, input int i);
    logic [1:0] er;
    er = v.err ? 2'b01 : 2'b00;
    @(posedge Hclk); #1;
    we1 = v.we; re1 = v.re; addr1 = v.addr; wdata1 = v.wdata;
    @(negedge Hclk);
    chk($sformatf("v%0d N ready", i), {31'd0, ready1}, 32'd0);
    chk($sformatf("v%0d N resp", i), {30'd0, resp1}, {30'd0, er});
    @(posedge Hclk); #1;
    we1 = 1'b0; re1 = 1'b0;
    @(negedge Hclk);
    chk($sformatf("v%0d N+1 ready", i), {31'd0, ready1}, 32'd1);
    chk($sformatf("v%0d N+1 resp", i), {30'd0, resp1}, {30'd0, er});
    chk($sformatf("v%0d read_data", i), rdata1, v.exp_rd);
  endtask

  // One OKAY transfer on the three-wait-state core; optionally drives a stray request while in WAIT.
  task automatic run3(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic inject, input string tag);
    @(posedge Hclk); #1;
    we3 = we; re3 = re; addr3 = a; wdata3 = d;
    @(negedge Hclk);
    chk({tag, " N ready"}, {31'd0, ready3}, 32'd0);
    chk({tag, " N resp"}, {30'd0, resp3}, 32'd0);
    @(posedge Hclk); #1;
    we3 = 1'b0; re3 = inject; addr3 = 32'h4;
    @(negedge Hclk);
    chk({tag, " N+1 ready"}, {31'd0, ready3}, 32'd0);
    chk({tag, " N+1 resp"}, {30'd0, resp3}, 32'd0);
    @(posedge Hclk); #1;
    re3 = 1'b0;
    @(negedge Hclk);
    chk({tag, " N+2 ready"}, {31'd0, ready3}, 32'd0);
    chk({tag, " N+2 resp"}, {30'd0, resp3}, 32'd0);
    @(posedge Hclk);
    @(negedge Hclk);
    chk({tag, " N+3 ready"}, {31'd0, ready3}, 32'd1);
    chk({tag, " N+3 resp"}, {30'd0, resp3}, 32'd0);
    chk({tag, " read_data"}, rdata3, exp_rd);
    @(negedge Hclk);
    chk({tag, " idle ready"}, {31'd0, ready3}, 32'd1);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    we1 = 1'b0; re1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    we3 = 1'b0; re3 = 1'b0; addr3 = 32'd0; wdata3 = 32'd0;

    //         we    re    addr         wdata          err   read_data after
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_0001, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hA5A5_0001};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1111_0000, 1'b0, 32'hA5A5_0001};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0003, 32'hDEAD_BEEF, 1'b1, 32'hA5A5_0001};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_0000};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h1111_0000};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 32'h1111_0000};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_0000};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_07FC, 32'h1234_5678, 1'b0, 32'h1111_0000};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_07FC, 32'h0000_0000, 1'b0, 32'h1234_5678};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0020, 32'h5A5A_5A5A, 1'b0, 32'h1234_5678};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h5A5A_5A5A};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hA5A5_0001};

`ifdef AHB_SLV_WPROT_EN
    dut1.mem_r[768] = 32'h0D0D_0D0D;
`endif

    // Asynchronous reset: outputs settle with no clock edge in between.
    Hresetn = 1'b1;
    #1 Hresetn = 1'b0;
    #1;
    chk("reset ready1", {31'd0, ready1}, 32'd1);
    chk("reset resp1", {30'd0, resp1}, 32'd0);
    chk("reset rdata1", rdata1, 32'd0);
    chk("reset ready3", {31'd0, ready3}, 32'd1);
    chk("reset rdata3", rdata3, 32'd0);
    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;

    // Each row starts in the cycle right after the previous completion, so 10->11 is back-to-back.
    for (int i = 0; i < 13; i++) begin
      run1(tbl[i], i);
    end

`ifdef AHB_SLV_WPROT_EN
    v = '{1'b1, 1'b0, 32'h0000_0C00, 32'hDEAD_BEEF, 1'b1, 32'hA5A5_0001};
    run1(v, 100);
    v = '{1'b0, 1'b1, 32'h0000_0C00, 32'h0000_0000, 1'b0, 32'h0D0D_0D0D};
    run1(v, 101);
`else
    v = '{1'b1, 1'b0, 32'h0000_0C00, 32'hBEEF_0C00, 1'b0, 32'hA5A5_0001};
    run1(v, 100);
    v = '{1'b0, 1'b1, 32'h0000_0C00, 32'h0000_0000, 1'b0, 32'hBEEF_0C00};
    run1(v, 101);
`endif

    // Three wait states; the stray read in WAIT must not disturb the transfer.
    run3(1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, "ws3 write");
    run3(1'b0, 1'b1, 32'h0, 32'h0000_0000, 32'h0BAD_F00D, 1'b1, "ws3 read");

    // Reset in the middle of a three-wait-state access.
    @(posedge Hclk); #1;
    we3 = 1'b1; addr3 = 32'h8; wdata3 = 32'h7777_7777;
    @(posedge Hclk); #1;
    we3 = 1'b0;
    @(negedge Hclk);
    chk("midwait ready", {31'd0, ready3}, 32'd0);
    Hresetn = 1'b0;
    #1;
    chk("midrst ready3", {31'd0, ready3}, 32'd1);
    chk("midrst resp3", {30'd0, resp3}, 32'd0);
    chk("midrst rdata3", rdata3, 32'd0);
    chk("midrst rdata1", rdata1, 32'd0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      chk($sformatf("postrst ready3 %0d", k), {31'd0, ready3}, 32'd1);
      chk($sformatf("postrst resp3 %0d", k), {30'd0, resp3}, 32'd0);
    end
    run3(1'b0, 1'b1, 32'h0, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, "ws3 reread");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
